// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types, sizes and sign-magnitude helpers for the batch divider
//
// Purpose : default word geometry, sequencer state encoding and sign-magnitude
//           split/pack helpers used by fp_div_batch_seq.
// Contents: FP_Q, FP_N, FP_NUM_CH, ITERS, state_t, sm_mag, sm_sign, sm_pack.
//           The helpers are sized by FP_N, so the top must be built with N == FP_N.

package fp_div_pkg;

  localparam int FP_Q      = 16;
  localparam int FP_N      = 48;
  localparam int FP_NUM_CH = 4;
  // One quotient bit per clock over the full |num| << Q dividend.
  localparam int ITERS     = FP_N - 1 + FP_Q;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [FP_N-2:0] sm_mag(input logic [FP_N-1:0] w);
    return w[FP_N-2:0];
  endfunction

  // A word with zero magnitude is treated as +0 whatever its sign bit says.
  function automatic logic sm_sign(input logic [FP_N-1:0] w);
    return w[FP_N-1] & (|w[FP_N-2:0]);
  endfunction

  // Never produces negative zero.
  function automatic logic [FP_N-1:0] sm_pack(input logic s, input logic [FP_N-2:0] m);
    return {s & (|m), m};
  endfunction

endpackage

// File: rtl/fp_div_serial_core.sv
// rtl/fp_div_serial_core.sv - serial restoring divider, one quotient bit per clock
//
// Purpose : divides (dividend_mag << Q) by divisor_mag, MSB first, in N-1+Q cycles.
// Ports   : clk, rst          clock, synchronous active-high reset
//           start             load operands and begin (ignored fields otherwise)
//           dividend_mag      unsigned numerator magnitude, N-1 bits
//           divisor_mag       unsigned denominator magnitude, N-1 bits
//           done              high in the cycle whose rising edge does the last iteration
//           quot              low N-1 quotient bits (valid after done)
//           dbz               divisor was zero
//           ovf               quotient >= 2^(N-1) (not reported when dbz)

module fp_div_serial_core #(
  parameter int Q = 16,
  parameter int N = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-2:0] dividend_mag,
  input  logic [N-2:0] divisor_mag,
  output logic         done,
  output logic [N-2:0] quot,
  output logic         dbz,
  output logic         ovf
);

  localparam int QW = N - 1 + Q;
  localparam int CW = $clog2(QW + 1);

  // qr starts as the shifted dividend and has quotient bits shifted in at the
  // bottom, so after QW steps it holds the whole quotient.
  logic [QW-1:0] qr;
  logic [N-2:0]  rem;
  logic [N-2:0]  dvs;
  logic [CW-1:0] cnt;
  logic          running;
  logic          dz;

  logic [N-1:0]  shifted;
  logic [N-1:0]  diff;
  logic          borrow;
  logic          geq;
  logic          unused_diff_msb;

  assign shifted          = {rem, qr[QW-1]};
  assign {borrow, diff}   = {1'b0, shifted} - {2'b0, dvs};
  assign geq              = ~borrow;
  // The partial remainder after a successful subtract is below the divisor,
  // so the top difference bit is always zero.
  assign unused_diff_msb  = diff[N-1];

  assign done = running && (cnt == CW'(1));
  assign quot = qr[N-2:0];
  assign dbz  = dz;
  assign ovf  = ~dz & (|qr[QW-1:N-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      qr      <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      dz      <= 1'b0;
    end else if (start) begin
      qr      <= {dividend_mag, {Q{1'b0}}};
      rem     <= '0;
      dvs     <= divisor_mag;
      dz      <= (divisor_mag == '0);
      cnt     <= CW'(QW);
      running <= 1'b1;
    end else if (running) begin
      qr  <= {qr[QW-2:0], geq};
      rem <= geq ? diff[N-2:0] : shifted[N-2:0];
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/fp_div_batch_seq.sv
// rtl/fp_div_batch_seq.sv - multi-channel sign-magnitude fixed-point divider sequencer
//
// Purpose : latches NUM_CH num/den pairs on start and divides them one channel at a
//           time on a shared serial core; reports quotient, dbz and ovf per channel.
// Ports   : clk, rst          clock, synchronous active-high reset
//           startbatch        start request, honoured only in IDLE or DONE
//           num_in, den_in    NUM_CH packed N-bit sign-magnitude operands
//           ans               NUM_CH packed N-bit quotients
//           dbz, ovf          per-channel divide-by-zero / overflow flags
//           busy              batch in progress
//           donebatch         level, batch finished, cleared by the next accepted start

module fp_div_batch_seq
  import fp_div_pkg::*;
#(
  parameter int Q      = FP_Q,
  parameter int N      = FP_N,
  parameter int NUM_CH = FP_NUM_CH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startbatch,
  input  logic [NUM_CH*N-1:0] num_in,
  input  logic [NUM_CH*N-1:0] den_in,
  output logic [NUM_CH*N-1:0] ans,
  output logic [NUM_CH-1:0]   dbz,
  output logic [NUM_CH-1:0]   ovf,
  output logic                busy,
  output logic                donebatch
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic [NUM_CH*N-1:0] num_r;
  logic [NUM_CH*N-1:0] den_r;

  logic [N-1:0] num_cur;
  logic [N-1:0] den_cur;
  logic         core_start;
  logic         core_done;
  logic         core_dbz;
  logic         core_ovf;
  logic [N-2:0] core_quot;

  logic         s_num;
  logic         s_q;
  logic         res_sign;
  logic [N-2:0] res_mag;
  logic [N-1:0] res_word;

  assign num_cur    = num_r[ch*N +: N];
  assign den_cur    = den_r[ch*N +: N];
  assign core_start = (state == S_LOAD);

  fp_div_serial_core #(.Q(Q), .N(N)) u_core (
    .clk          (clk),
    .rst          (rst),
    .start        (core_start),
    .dividend_mag (sm_mag(num_cur)),
    .divisor_mag  (sm_mag(den_cur)),
    .done         (core_done),
    .quot         (core_quot),
    .dbz          (core_dbz),
    .ovf          (core_ovf)
  );

  // Result formatting for the channel being stored. Operands stay latched for
  // the whole batch, so the signs can be taken straight from them here.
  always_comb begin
    s_num    = sm_sign(num_cur);
    s_q      = s_num ^ sm_sign(den_cur);
    res_mag  = core_quot;
    res_sign = s_q;
    if (core_dbz) begin
      res_mag  = '1;
      res_sign = s_num;
    end else if (core_ovf) begin
      res_mag  = '1;
    end
    res_word = sm_pack(res_sign, res_mag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      num_r     <= '0;
      den_r     <= '0;
      ans       <= '0;
      dbz       <= '0;
      ovf       <= '0;
      busy      <= 1'b0;
      donebatch <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (startbatch) begin
            num_r     <= num_in;
            den_r     <= den_in;
            ans       <= '0;
            dbz       <= '0;
            ovf       <= '0;
            donebatch <= 1'b0;
            busy      <= 1'b1;
            ch        <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: state <= S_ITER;
        S_ITER: begin
          if (core_done) state <= S_STORE;
        end
        S_STORE: begin
          ans[ch*N +: N] <= res_word;
          dbz[ch]        <= core_dbz;
          ovf[ch]        <= core_ovf;
          if (ch == CH_W'(NUM_CH - 1)) begin
            busy      <= 1'b0;
            donebatch <= 1'b1;
            state     <= S_DONE;
          end else begin
            ch    <= ch + CH_W'(1);
            state <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
